// File: rtl/rr_grant_arbiter16_if.sv
// Request/grant bundle between the 16 requesters and the round-robin arbiter.
// The requester side drives req/done; the arbiter side drives the grant outputs.
interface rr_grant_arbiter16_if;
   logic [15:0] req;
   logic        done;
   logic [15:0] gnt;
   logic [3:0]  gnt_idx;
   logic        gnt_valid;
   logic        timeout;

   modport master (
      output req,
      output done,
      input  gnt,
      input  gnt_idx,
      input  gnt_valid,
      input  timeout
   );

   modport slave (
      input  req,
      input  done,
      output gnt,
      output gnt_idx,
      output gnt_valid,
      output timeout
   );
endinterface

// File: rtl/rr_grant_arbiter16.sv
// Round-robin arbiter for 16 requesters.
// A winner is picked in IDLE by scanning upward from the last owner.
// The winner holds the resource until it releases, drops its request, or
// uses up MAX_HOLD cycles. One GAP cycle always separates two owners.
// All outputs come straight from registers.
module rr_grant_arbiter16 #(
   parameter int MAX_HOLD = 8
) (
   input logic                 clk,
   input logic                 rst,
   rr_grant_arbiter16_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [3:0]  ptr;
   logic [3:0]  ptr_next;
   logic [7:0]  hold_cnt;
   logic [7:0]  hold_cnt_next;
   logic [15:0] gnt_q;
   logic [15:0] gnt_next;
   logic [3:0]  idx_q;
   logic [3:0]  idx_next;
   logic        valid_q;
   logic        valid_next;
   logic        timeout_q;
   logic        timeout_next;

   logic        found;
   logic [3:0]  winner;
   logic [3:0]  cand;
   logic        release_req;
   logic        hold_done;

   // Scan candidates ptr+1 .. ptr+16 (mod 16). The first requesting index wins.
   always_comb begin
      found  = 1'b0;
      winner = ptr;
      cand   = ptr;
      for (int k = 1; k <= 16; k++) begin
         cand = ptr + 4'(k);
         if (!found && bus.req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   assign release_req = bus.done | ~bus.req[idx_q];
   assign hold_done   = (hold_cnt == 8'(MAX_HOLD));

   // Compute the next state and the next registered outputs.
   // A timeout is reported only when the hold budget alone ends the ownership.
   always_comb begin
      state_next    = state;
      ptr_next      = ptr;
      hold_cnt_next = hold_cnt;
      gnt_next      = gnt_q;
      idx_next      = idx_q;
      valid_next    = valid_q;
      timeout_next  = 1'b0;

      case (state)
         IDLE: begin
            if (found) begin
               state_next    = GRANT;
               idx_next      = winner;
               gnt_next      = 16'd1 << winner;
               valid_next    = 1'b1;
               hold_cnt_next = 8'd1;
            end
         end
         GRANT: begin
            if (release_req || hold_done) begin
               state_next   = GAP;
               gnt_next     = 16'd0;
               valid_next   = 1'b0;
               ptr_next     = idx_q;
               timeout_next = hold_done & ~release_req;
            end else begin
               hold_cnt_next = hold_cnt + 8'd1;
            end
         end
         GAP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
            gnt_next   = 16'd0;
            valid_next = 1'b0;
         end
      endcase
   end

   // State and output registers. Reset puts ptr at 15 so requester 0 goes first.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= 4'd15;
         hold_cnt  <= 8'd0;
         gnt_q     <= 16'd0;
         idx_q     <= 4'd0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_next;
         ptr       <= ptr_next;
         hold_cnt  <= hold_cnt_next;
         gnt_q     <= gnt_next;
         idx_q     <= idx_next;
         valid_q   <= valid_next;
         timeout_q <= timeout_next;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_idx   = idx_q;
   assign bus.gnt_valid = valid_q;
   assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter16.sv
// Scoreboard bench for rr_grant_arbiter16.
// The driver predicts each cycle's outputs with an ownership-level model and
// queues them. The monitor pops one prediction per cycle and compares.
module tb_rr_grant_arbiter16;

   localparam int MAX_HOLD = 8;

   logic clk = 1'b0;
   logic rst;

   rr_grant_arbiter16_if bus ();

   rr_grant_arbiter16 #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] gnt;
      logic [3:0]  idx;
      logic        valid;
      logic        timeout;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;

   // Model state: current owner (-1 = none), cycles it has held, last owner,
   // last index shown, and how many cycles must pass before arbitration.
   int   m_owner   = -1;
   int   m_held    = 0;
   int   m_last    = 15;
   int   m_idx     = 0;
   int   m_cool    = 0;
   bit   m_timeout = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic modelStep(input logic [15:0] r, input logic d, input logic rs);
      exp_t e;
      bit   rel;
      bit   expired;
      bit   found;
      int   c;
      if (rs) begin
         m_owner   = -1;
         m_held    = 0;
         m_last    = 15;
         m_idx     = 0;
         m_cool    = 0;
         m_timeout = 1'b0;
      end else if (m_owner >= 0) begin
         rel     = d || !r[m_owner];
         expired = (m_held == MAX_HOLD);
         if (rel || expired) begin
            m_timeout = !rel;
            m_last    = m_owner;
            m_owner   = -1;
            m_cool    = 1;
         end else begin
            m_held++;
            m_timeout = 1'b0;
         end
      end else begin
         m_timeout = 1'b0;
         if (m_cool > 0) begin
            m_cool--;
         end else if (r != 16'd0) begin
            found = 1'b0;
            for (int k = 1; k <= 16; k++) begin
               c = (m_last + k) % 16;
               if (!found && r[c]) begin
                  found   = 1'b1;
                  m_owner = c;
               end
            end
            m_held = 1;
            m_idx  = m_owner;
         end
      end
      e.valid   = (m_owner >= 0);
      e.idx     = 4'(m_idx);
      e.gnt     = e.valid ? (16'd1 << m_idx) : 16'd0;
      e.timeout = m_timeout;
      exp_q.push_back(e);
   endtask

   task automatic applyStimulus(input logic [15:0] r, input logic d, input logic rs);
      bus.req  = r;
      bus.done = d;
      rst      = rs;
      @(posedge clk);
      modelStep(r, d, rs);
      #1;
   endtask

   // Monitor: compare the outputs of each cycle with the queued prediction,
   // and check the grant encoding invariant.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         checkOutput("gnt", 32'(bus.gnt), 32'(mon_e.gnt));
         checkOutput("gnt_idx", 32'(bus.gnt_idx), 32'(mon_e.idx));
         checkOutput("gnt_valid", 32'(bus.gnt_valid), 32'(mon_e.valid));
         checkOutput("timeout", 32'(bus.timeout), 32'(mon_e.timeout));
         checkOutput("onehot", 32'((bus.gnt & (bus.gnt - 16'd1)) == 16'd0), 32'd1);
         checkOutput("gnt_vs_idx", 32'(bus.gnt),
                     32'(bus.gnt_valid ? (16'd1 << bus.gnt_idx) : 16'd0));
      end
   end

   // Directed scenarios followed by a randomized run.
   initial begin
      bit dropped;

      applyStimulus(16'h0000, 1'b0, 1'b1);
      applyStimulus(16'h0000, 1'b0, 1'b1);

      $display("[TB] rotation with done on third grant cycle");
      for (int c = 0; c < 90; c++)
         applyStimulus(16'hFFFF, (m_owner >= 0 && m_held == 3), 1'b0);

      $display("[TB] hold budget expiry with wrap 15->0");
      applyStimulus(16'h0000, 1'b0, 1'b1);
      for (int c = 0; c < 45; c++)
         applyStimulus(16'h8001, 1'b0, 1'b0);

      $display("[TB] single requester drops request");
      applyStimulus(16'h0000, 1'b0, 1'b1);
      dropped = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (m_owner == 5 && m_held == 3)
            dropped = 1'b1;
         applyStimulus(dropped ? 16'h0000 : 16'h0020, 1'b0, 1'b0);
      end

      $display("[TB] done coincident with hold budget");
      applyStimulus(16'h0000, 1'b0, 1'b1);
      for (int c = 0; c < 25; c++)
         applyStimulus(16'h0010, (m_owner >= 0 && m_held == MAX_HOLD), 1'b0);

      $display("[TB] reset during grant");
      applyStimulus(16'h0000, 1'b0, 1'b1);
      for (int c = 0; c < 10 && !(m_owner == 9 && m_held == 2); c++)
         applyStimulus(16'h0200, 1'b0, 1'b0);
      applyStimulus(16'h0201, 1'b0, 1'b1);
      for (int c = 0; c < 8; c++)
         applyStimulus(16'h0201, 1'b0, 1'b0);

      $display("[TB] idle with no requests");
      for (int c = 0; c < 20; c++)
         applyStimulus(16'h0000, 1'b0, 1'b0);

      $display("[TB] randomized traffic");
      for (int c = 0; c < 400; c++)
         applyStimulus(16'($urandom) & 16'($urandom),
                       ($urandom_range(0, 5) == 0),
                       ($urandom_range(0, 99) == 0));

      @(negedge clk);
      #1;
      checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
